// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, reads the combinational ROM once
// per cycle, and buffers fetched words in a 2-entry queue for decode.
module imem_fetch_ctrl #(
  parameter int              N         = 32,
  parameter int              INS       = 1000,
  parameter logic [N-1:0]    HALT_WORD = {N{1'b1}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] start_pc,
  input  logic         redirect,
  input  logic [N-1:0] redirect_pc,
  output logic [N-1:0] imem_pc,
  input  logic [N-1:0] imem_instr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_instr,
  output logic [N-1:0] out_pc,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [N-1:0] INS_LIM = N'(INS);

  state_t       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [1:0]   count_q, count_d;
  // Entry 0 is always the queue head; entry 1 is the younger word.
  logic [N-1:0] q_pc_q    [0:1];
  logic [N-1:0] q_pc_d    [0:1];
  logic [N-1:0] q_instr_q [0:1];
  logic [N-1:0] q_instr_d [0:1];

  logic       pop;
  logic [1:0] cnt_after_pop;

  assign pop           = (count_q != 2'd0) && out_ready;
  assign cnt_after_pop = count_q - {1'b0, pop};

  // Next-state logic: start, redirect/flush, fetch/push, pop and drain.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    count_d      = count_q;
    q_pc_d[0]    = q_pc_q[0];
    q_pc_d[1]    = q_pc_q[1];
    q_instr_d[0] = q_instr_q[0];
    q_instr_d[1] = q_instr_q[1];

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          pc_d    = start_pc;
          count_d = 2'd0;
          state_d = S_FETCH;
        end
      end
      S_FETCH, S_DRAIN: begin
        if (redirect) begin
          // A same-cycle handshake still consumes the head; everything else
          // in the queue belongs to the abandoned path.
          count_d = 2'd0;
          pc_d    = redirect_pc;
          state_d = S_FETCH;
        end else begin
          if (pop) begin
            q_pc_d[0]    = q_pc_q[1];
            q_instr_d[0] = q_instr_q[1];
          end
          count_d = cnt_after_pop;
          if (state_q == S_FETCH) begin
            if (pc_q >= INS_LIM) begin
              state_d = S_DRAIN;
            end else if (count_q < 2'd2) begin
              // Fullness uses the pre-pop count so the ROM read never depends
              // on out_ready.
              q_pc_d[cnt_after_pop[0]]    = pc_q;
              q_instr_d[cnt_after_pop[0]] = imem_instr;
              count_d = cnt_after_pop + 2'd1;
              pc_d    = pc_q + 1'b1;
              if (imem_instr == HALT_WORD) state_d = S_DRAIN;
            end
          end else if (cnt_after_pop == 2'd0) begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, PC and queue registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      count_q      <= 2'd0;
      // NOTE: the queue storage is reset too, because out_pc/out_instr are
      // read straight from entry 0 and must be 0 out of reset.
      q_pc_q[0]    <= '0;
      q_pc_q[1]    <= '0;
      q_instr_q[0] <= '0;
      q_instr_q[1] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q      <= state_d;
      pc_q         <= pc_d;
      count_q      <= count_d;
      q_pc_q[0]    <= q_pc_d[0];
      q_pc_q[1]    <= q_pc_d[1];
      q_instr_q[0] <= q_instr_d[0];
      q_instr_q[1] <= q_instr_d[1];
    end
  end

  assign imem_pc   = pc_q;
  assign out_valid = (count_q != 2'd0);
  assign out_pc    = q_pc_q[0];
  assign out_instr = q_instr_q[0];
  assign busy      = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);

endmodule
